pe_rram_bs: RTL and testbench
=============================

# pe_rram_bs

Bit-serial, multi-bit successor of the single-bit RRAM crossbar PE. It holds a ROW x COL binary RRAM array (behavioural model) and accepts one XBITS-wide input vector per operation. It streams the vector MSB-plane first, modelling per-plane analog settle time, and returns a full-precision dot product per column over a valid/ready handshake. It sits between the activation buffer (input side) and the column-result collector (output side), with a separate program/read port for the array.

## Interface
Parameters:
- ROW, 36, word lines (array rows).
- COL, 16, bit lines (array columns).
- XBITS, 4, input precision in bits (unsigned).
- RA_W, $clog2(ROW), row address width (derived).
- CA_W, $clog2(COL), column address width (derived).
- ACC_W, $clog2(ROW+1)+XBITS, per-column result width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_row  in  RA_W  cell row for program/read.
- addr_col  in  CA_W  cell column for program/read.
- wr_en  in  1  program request.
- wr_set  in  1  set cell to 1.
- wr_rst  in  1  reset cell to 0.
- rd_en  in  1  cell read request.
- rd_data  out  1  cell value.
- rd_valid  out  1  rd_data valid, single-cycle pulse.
- cfg_err  out  1  single-cycle pulse: wr_en/rd_en dropped.
- xin  in  ROW*XBITS  input vector; row r at xin[r*XBITS +: XBITS].
- in_valid  in  1  xin valid.
- in_ready  out  1  block can accept xin.
- acc_out  out  COL*ACC_W  column c result at acc_out[c*ACC_W +: ACC_W].
- out_valid  out  1  acc_out valid.
- out_ready  in  1  downstream accepts acc_out.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, PLANE, DONE.
- IDLE: program/read port active.
  - wr_en with wr_set=1, wr_rst=0: cell[addr_col][addr_row] <= 1.
  - wr_en with wr_set=0, wr_rst=1: cell <= 0.
  - wr_en with both or neither set: no change, no error.
  - addr_row >= ROW: write ignored; read returns 0.
- Program/read outside IDLE: request dropped, cfg_err pulses next cycle, array unchanged.
- in_ready = (state==IDLE) && !wr_en && !rd_en; a program or read request in the same cycle takes priority over compute start.
- Accept (in_valid && in_ready):
  - capture xin into an internal register; later xin changes have no effect.
  - clear all accumulators; plane index p = XBITS-1; dwell counter = 0; go to PLANE.
- PLANE, bit-plane p:
  - plane vector b[r] = x_r[p]; dwell d_p = max(1, popcount(b)), max ROW.
  - Dwell counter counts 0..d_p-1.
  - In the cycle where counter == d_p-1, every column updates acc[c] <= (acc[c] << 1) + popcount(cell[c] & b), width ACC_W, no overflow possible.
  - If p == 0, go to DONE; else p <= p-1 and counter <= 0.
- DONE: out_valid=1 with acc_out stable. On out_valid && out_ready, go to IDLE, with out_valid low next cycle.
- Final result: acc[c] = sum over rows r of cell[c][r] * x_r, unsigned.
- Reset: state IDLE, accumulators 0, whole array cleared to 0 (behavioural model), captured xin 0.

## Timing
- Reset values: rd_data=0, rd_valid=0, cfg_err=0, in_ready=1 in the first cycle after reset if wr_en/rd_en are low, acc_out=0, out_valid=0, busy=0.
- Program: cell updated at the edge sampling wr_en. A read of the same cell in the next cycle sees the new value.
- Read: rd_data/rd_valid valid in the cycle after the rd_en edge.
- Compute latency: out_valid rises sum(d_p) edges after the accept edge. Minimum is XBITS, reached when all planes are zero.
- busy is high from the cycle after accept until the cycle after the out handshake.
- Back-to-back: the earliest next accept is the cycle after the out handshake.
- out_ready held low: stay in DONE indefinitely, acc_out unchanged.
- rst asserted mid-PLANE or in DONE: next cycle is IDLE, out_valid=0, and the array is cleared.

## Test plan
All scenarios use ROW=8, COL=4, XBITS=4.
- Reset then idle: all outputs at reset values; in_ready=1; reading any cell returns rd_data=0 with rd_valid one cycle later.
- Program col0 rows0-7 = 1, col1 row0 = 1; every row x=5 -> dwells 1,8,1,8; out_valid 18 edges after accept; acc_out = {0,0,5,40} (col3..col0).
- All-zero input, any array contents -> out_valid exactly 4 edges after accept; all acc_out = 0.
- Maximum value: array all 1, every x=15 -> every acc = 120; dwell 8 per plane; latency 32.
- wr_en during PLANE -> cfg_err pulse, cell unchanged (checked by read after DONE). wr_en and in_valid in the same IDLE cycle -> write done, in_ready=0, accept on the following cycle.
- Hold out_ready=0 for 10 cycles in DONE -> acc_out stable; then pulse out_ready -> IDLE. Separately, rst mid-PLANE -> IDLE next cycle, out_valid never asserted.

Source files
------------

// File: rtl/pe_rram_bs_if.sv
// rtl/pe_rram_bs_if.sv - bus bundle for the bit-serial RRAM crossbar PE
//
// Purpose: groups the program/read port, the input-vector handshake and the
//          column-result handshake of pe_rram_bs.
// Signals:
//   addr_row, addr_col, wr_en, wr_set, wr_rst, rd_en  -> cell program/read request
//   rd_data, rd_valid, cfg_err                       <- cell read result / dropped request
//   xin, in_valid / in_ready                         -> input vector handshake
//   acc_out, out_valid / out_ready                   <- column result handshake
//   busy                                             <- compute in progress
// Modports: master drives requests (activation side), slave is the PE.
interface pe_rram_bs_if #(
  parameter int ROW   = 36,
  parameter int COL   = 16,
  parameter int XBITS = 4
);
  localparam int RA_W  = $clog2(ROW);
  localparam int CA_W  = $clog2(COL);
  localparam int ACC_W = $clog2(ROW + 1) + XBITS;

  logic [RA_W-1:0]        addr_row;
  logic [CA_W-1:0]        addr_col;
  logic                   wr_en;
  logic                   wr_set;
  logic                   wr_rst;
  logic                   rd_en;
  logic                   rd_data;
  logic                   rd_valid;
  logic                   cfg_err;
  logic [ROW*XBITS-1:0]   xin;
  logic                   in_valid;
  logic                   in_ready;
  logic [COL*ACC_W-1:0]   acc_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output addr_row, addr_col, wr_en, wr_set, wr_rst, rd_en,
    output xin, in_valid, out_ready,
    input  rd_data, rd_valid, cfg_err, in_ready, acc_out, out_valid, busy
  );

  modport slave (
    input  addr_row, addr_col, wr_en, wr_set, wr_rst, rd_en,
    input  xin, in_valid, out_ready,
    output rd_data, rd_valid, cfg_err, in_ready, acc_out, out_valid, busy
  );
endinterface

// File: rtl/pe_rram_bs.sv
// rtl/pe_rram_bs.sv - bit-serial multi-bit RRAM crossbar processing element
//
// Purpose: holds a ROW x COL binary cell array and computes, per column, the
//          unsigned dot product of the column cells with an XBITS-wide input
//          vector, streamed MSB bit-plane first with a per-plane dwell time.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset (also clears the array)
//   bus    - pe_rram_bs_if.slave: program/read port, input and result handshakes
module pe_rram_bs #(
  parameter int ROW   = 36,
  parameter int COL   = 16,
  parameter int XBITS = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pe_rram_bs_if.slave  bus
);
  localparam int ACC_W = $clog2(ROW + 1) + XBITS;
  localparam int CNT_W = $clog2(ROW + 1);
  localparam int P_W   = (XBITS > 1) ? $clog2(XBITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLANE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ROW-1:0]       r_cell [COL];
  logic [ROW*XBITS-1:0] r_x;
  logic [P_W-1:0]       r_p;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_W-1:0]     r_acc [COL];
  logic                 r_rd_data;
  logic                 r_rd_valid;
  logic                 r_cfg_err;

  logic [ROW-1:0]       w_b;
  logic [CNT_W-1:0]     w_pc;
  logic [CNT_W-1:0]     w_dwell;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_addr_ok;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [ROW-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROW; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Current bit-plane and its analog settle time: one cycle per active word
  // line, never less than one cycle.
  always_comb begin
    w_b = '0;
    for (int r = 0; r < ROW; r++) w_b[r] = r_x[r*XBITS + int'(r_p)];
  end

  assign w_pc      = f_popcount(w_b);
  assign w_dwell   = (w_pc == '0) ? CNT_W'(1) : w_pc;
  assign w_last    = (r_cnt == w_dwell - CNT_W'(1));
  assign w_addr_ok = (int'(bus.addr_row) < ROW) && (int'(bus.addr_col) < COL);
  assign w_accept  = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_next  = r_state;
    w_in_ready    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // A program/read request in the same cycle wins over compute start.
        w_in_ready   = !bus.wr_en && !bus.rd_en;
        bus.in_ready = w_in_ready;
        if (bus.in_valid && w_in_ready) w_state_next = S_PLANE;
      end
      S_PLANE: begin
        if (w_last && (r_p == '0)) w_state_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_rd_data  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_cfg_err  <= 1'b0;
      for (int c = 0; c < COL; c++) begin
        r_cell[c] <= '0;
        r_acc[c]  <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= 1'b0;
      r_cfg_err  <= 1'b0;

      if (r_state == S_IDLE) begin
        // Exactly one of set/reset must be asserted for a program to act.
        if (bus.wr_en && w_addr_ok && (bus.wr_set ^ bus.wr_rst))
          r_cell[bus.addr_col][bus.addr_row] <= bus.wr_set;
        if (bus.rd_en) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= w_addr_ok ? r_cell[bus.addr_col][bus.addr_row] : 1'b0;
        end
      end else if (bus.wr_en || bus.rd_en) begin
        r_cfg_err <= 1'b1;
      end

      if (w_accept) begin
        r_x   <= bus.xin;
        r_p   <= P_W'(XBITS - 1);
        r_cnt <= '0;
        for (int c = 0; c < COL; c++) r_acc[c] <= '0;
      end

      if (r_state == S_PLANE) begin
        if (w_last) begin
          // Shift-and-add: MSB plane first, so earlier planes end up weighted
          // by their bit position once all planes are in.
          for (int c = 0; c < COL; c++)
            r_acc[c] <= (r_acc[c] << 1) + ACC_W'(f_popcount(r_cell[c] & w_b));
          if (r_p != '0) begin
            r_p   <= r_p - P_W'(1);
            r_cnt <= '0;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.cfg_err  = r_cfg_err;

  for (genvar c = 0; c < COL; c++) begin : g_acc
    assign bus.acc_out[c*ACC_W +: ACC_W] = r_acc[c];
  end
endmodule

// File: tb/tb_pe_rram_bs.sv
// tb/tb_pe_rram_bs.sv - self-checking bench for pe_rram_bs
module tb_pe_rram_bs;
  localparam int ROW   = 8;
  localparam int COL   = 4;
  localparam int XBITS = 4;
  localparam int ACC_W = $clog2(ROW + 1) + XBITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_rram_bs_if #(.ROW(ROW), .COL(COL), .XBITS(XBITS)) bus ();

  pe_rram_bs #(.ROW(ROW), .COL(COL), .XBITS(XBITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit        m_cell [COL][ROW];
  logic [3:0] xs [ROW];
  logic [COL*ACC_W-1:0] last_acc;
  int        last_lat;
  int        inj_c, inj_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int c, input int r, input bit v);
    bus.addr_col = 2'(c);
    bus.addr_row = 3'(r);
    bus.wr_set   = v;
    bus.wr_rst   = !v;
    bus.wr_en    = 1'b1;
    tick();
    bus.wr_en    = 1'b0;
    m_cell[c][r] = v;
  endtask

  task automatic rd_chk(input int c, input int r, input string tag);
    bus.addr_col = 2'(c);
    bus.addr_row = 3'(r);
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en    = 1'b0;
    chk({tag, "_rv"}, 64'(bus.rd_valid), 64'd1);
    chk({tag, "_rd"}, 64'(bus.rd_data), 64'(m_cell[c][r]));
    tick();
    chk({tag, "_rv0"}, 64'(bus.rd_valid), 64'd0);
  endtask

  // Reference: dot product per column and sum of per-plane dwell times.
  task automatic model(output logic [COL*ACC_W-1:0] exp_acc, output int exp_lat);
    int n;
    exp_acc = '0;
    for (int c = 0; c < COL; c++) begin
      int s = 0;
      for (int r = 0; r < ROW; r++) if (m_cell[c][r]) s += int'(xs[r]);
      exp_acc[c*ACC_W +: ACC_W] = ACC_W'(s);
    end
    exp_lat = 0;
    for (int p = XBITS - 1; p >= 0; p--) begin
      n = 0;
      for (int r = 0; r < ROW; r++) n += int'(xs[r][p]);
      exp_lat += (n == 0) ? 1 : n;
    end
  endtask

  task automatic do_op(input int hold, input bit inject_wr, input bit pre_wr, input string tag);
    logic [COL*ACC_W-1:0] exp_acc;
    logic [ROW*XBITS-1:0] xv;
    int exp_lat, cnt;
    for (int r = 0; r < ROW; r++) xv[r*XBITS +: XBITS] = xs[r];
    if (pre_wr) begin
      bus.addr_col = 2'd3; bus.addr_row = 3'd7;
      bus.wr_set = 1'b1; bus.wr_rst = 1'b0; bus.wr_en = 1'b1;
      bus.xin = xv; bus.in_valid = 1'b1;
      #1;
      chk({tag, "_rdy_blk"}, 64'(bus.in_ready), 64'd0);
      tick();
      bus.wr_en = 1'b0;
      m_cell[3][7] = 1'b1;
      #1;
      chk({tag, "_busy_pre"}, 64'(bus.busy), 64'd0);
    end
    model(exp_acc, exp_lat);
    bus.xin = xv;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.xin = ($urandom() % 2 == 0) ? '1 : ~xv;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    cnt = 0;
    if (inject_wr) begin
      inj_c = $urandom_range(0, COL - 1);
      inj_r = $urandom_range(0, ROW - 1);
      bus.addr_col = 2'(inj_c); bus.addr_row = 3'(inj_r);
      bus.wr_set = !m_cell[inj_c][inj_r]; bus.wr_rst = m_cell[inj_c][inj_r];
      bus.wr_en = 1'b1;
      tick();
      cnt++;
      bus.wr_en = 1'b0;
      chk({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'd1);
    end
    while (!bus.out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    last_lat = cnt;
    last_acc = bus.acc_out;
    chk({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
    chk({tag, "_acc"}, 64'(bus.acc_out), 64'(exp_acc));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_acc"}, 64'(bus.acc_out), 64'(exp_acc));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ov0"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy0"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int ov_seen;
    bus.addr_row = '0; bus.addr_col = '0;
    bus.wr_en = 1'b0; bus.wr_set = 1'b0; bus.wr_rst = 1'b0; bus.rd_en = 1'b0;
    bus.xin = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int c = 0; c < COL; c++) for (int r = 0; r < ROW; r++) m_cell[c][r] = 1'b0;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_acc", 64'(bus.acc_out), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 4; i++) rd_chk($urandom_range(0, COL - 1), $urandom_range(0, ROW - 1), "rst_read");

    for (int r = 0; r < ROW; r++) prog(0, r, 1'b1);
    prog(1, 0, 1'b1);
    rd_chk(1, 0, "prog_read");
    for (int r = 0; r < ROW; r++) xs[r] = 4'd5;
    do_op(0, 1'b0, 1'b0, "x5");
    chk("x5_const_acc", 64'(last_acc), 64'h0000_0528);
    chk("x5_const_lat", 64'(last_lat), 64'd18);

    for (int i = 0; i < 6; i++) prog($urandom_range(0, COL - 1), $urandom_range(0, ROW - 1), 1'($urandom_range(0, 1)));
    for (int r = 0; r < ROW; r++) xs[r] = 4'd0;
    do_op(0, 1'b0, 1'b0, "zero");
    chk("zero_const_lat", 64'(last_lat), 64'd4);
    chk("zero_const_acc", 64'(last_acc), 64'd0);

    for (int c = 0; c < COL; c++) for (int r = 0; r < ROW; r++) prog(c, r, 1'b1);
    for (int r = 0; r < ROW; r++) xs[r] = 4'd15;
    do_op(0, 1'b0, 1'b0, "max");
    chk("max_const_acc", 64'(last_acc), 64'h7878_7878);
    chk("max_const_lat", 64'(last_lat), 64'd32);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) prog($urandom_range(0, COL - 1), $urandom_range(0, ROW - 1), 1'($urandom_range(0, 1)));
      for (int r = 0; r < ROW; r++) xs[r] = 4'($urandom_range(0, 15));
      do_op($urandom_range(0, 2), 1'b0, 1'b0, "rand");
    end

    bus.addr_col = 2'd2; bus.addr_row = 3'd5;
    bus.wr_set = 1'b1; bus.wr_rst = 1'b1; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    rd_chk(2, 5, "both_set");

    for (int r = 0; r < ROW; r++) xs[r] = 4'($urandom_range(0, 15));
    do_op(0, 1'b1, 1'b0, "inj");
    rd_chk(inj_c, inj_r, "inj_read");

    prog(3, 7, 1'b0);
    for (int r = 0; r < ROW; r++) xs[r] = 4'($urandom_range(1, 15));
    xs[7] = 4'd9;
    do_op(0, 1'b0, 1'b1, "prewr");

    for (int r = 0; r < ROW; r++) xs[r] = 4'($urandom_range(0, 15));
    do_op(10, 1'b0, 1'b0, "hold");

    for (int r = 0; r < ROW; r++) bus.xin[r*XBITS +: XBITS] = 4'd15;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ov", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_rdy", 64'(bus.in_ready), 64'd1);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) ov_seen++;
    end
    chk("midrst_no_ov", 64'(ov_seen), 64'd0);
    for (int c = 0; c < COL; c++) for (int r = 0; r < ROW; r++) m_cell[c][r] = 1'b0;
    rd_chk(0, 0, "midrst_clr");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
